// File: rtl/instr_aligner.sv
// instr_aligner: realigns a word-fetched RISC-V stream of 16/32-bit instructions for the decoder
// Ports:
//   I_clk, I_reset             clock, asynchronous active-high reset
//   I_redirect, I_redirect_pc  flush the buffer and restart fetch at a new PC
//   O_mem_req, O_mem_addr      single outstanding word fetch, held until I_mem_ack
//   I_mem_ack, I_mem_data      one-cycle fetch response carrying a little-endian word
//   O_valid, O_instr, O_pc     head instruction of the halfword buffer and its address
//   O_is_compressed            head is a 16-bit instruction
//   I_ready                    decoder accepts the head instruction
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_pc,
    output logic        O_mem_req,
    output logic [31:0] O_mem_addr,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_data,
    output logic        O_valid,
    output logic [31:0] O_instr,
    output logic [31:0] O_pc,
    output logic        O_is_compressed,
    input  logic        I_ready
);
    typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;
    state_t      state, state_next;
    logic [47:0] hw_buf, hw_buf_next;
    logic [1:0]  hw_cnt, hw_cnt_next, need, pop, push, cnt_popped;
    logic [31:0] pc, fetch_addr, push_data;
    logic        skip_lo, xfer, take;

    // hw_buf[15:0] is the head halfword; slots above hw_cnt are kept zero so pushes can be OR-ed in
    always_comb begin
        O_is_compressed = hw_buf[1:0] != 2'b11;
        need            = O_is_compressed ? 2'd1 : 2'd2;
        O_valid         = hw_cnt >= need;
        O_instr         = O_is_compressed ? {16'h0, hw_buf[15:0]} : hw_buf[31:0];
        O_pc            = pc;
        O_mem_req       = state == WAIT;
        O_mem_addr      = fetch_addr;
        xfer            = O_valid && I_ready && !I_redirect;
        take            = state == WAIT && I_mem_ack && !I_redirect;
        pop             = xfer ? need : 2'd0;
        cnt_popped      = hw_cnt - pop;
        push            = take ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
        // the first word after a redirect to an odd halfword contributes only its upper half
        push_data       = skip_lo ? {16'h0, I_mem_data[31:16]} : I_mem_data;
        hw_buf_next     = I_redirect ? 48'h0 :
                          (hw_buf >> {pop, 4'b0}) | (take ? ({16'h0, push_data} << {cnt_popped, 4'b0}) : 48'h0);
        hw_cnt_next     = I_redirect ? 2'd0 : cnt_popped + push;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     state_next = (!I_redirect && cnt_popped <= 2'd1) ? WAIT : RUN;
            // a redirect with the fetch still in flight must swallow its late response
            WAIT:    state_next = I_mem_ack ? RUN : (I_redirect ? DROP : WAIT);
            DROP:    state_next = I_mem_ack ? RUN : DROP;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state      <= RUN;
            hw_buf     <= 48'h0;
            hw_cnt     <= 2'd0;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC & ~32'h3;
            skip_lo    <= RESET_PC[1];
        end else begin
            state  <= state_next;
            hw_buf <= hw_buf_next;
            hw_cnt <= hw_cnt_next;
            if (I_redirect) begin
                pc         <= I_redirect_pc & ~32'h1;
                fetch_addr <= I_redirect_pc & ~32'h3;
                skip_lo    <= I_redirect_pc[1];
            end else begin
                if (xfer)
                    pc <= pc + {29'h0, need, 1'b0};
                if (take) begin
                    fetch_addr <= fetch_addr + 32'd4;
                    skip_lo    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: directed scenarios plus a randomized fetch/redirect run against a PC-level instruction model
module tb_instr_aligner;
    logic        I_clk = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_redirect = 1'b0;
    logic [31:0] I_redirect_pc = 32'h0;
    logic        O_mem_req;
    logic [31:0] O_mem_addr;
    logic        I_mem_ack = 1'b0;
    logic [31:0] I_mem_data = 32'h0;
    logic        O_valid;
    logic [31:0] O_instr;
    logic [31:0] O_pc;
    logic        O_is_compressed;
    logic        I_ready = 1'b0;

    int nvec = 0;
    int nerr = 0;

    instr_aligner dut (
        .I_clk(I_clk), .I_reset(I_reset), .I_redirect(I_redirect), .I_redirect_pc(I_redirect_pc),
        .O_mem_req(O_mem_req), .O_mem_addr(O_mem_addr), .I_mem_ack(I_mem_ack), .I_mem_data(I_mem_data),
        .O_valid(O_valid), .O_instr(O_instr), .O_pc(O_pc), .O_is_compressed(O_is_compressed),
        .I_ready(I_ready)
    );

    always #5 I_clk = ~I_clk;

    task automatic tick;
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset;
        I_reset = 1'b1; I_redirect = 1'b0; I_mem_ack = 1'b0; I_ready = 1'b0;
        tick; tick;
        I_reset = 1'b0;
    endtask

    task automatic ack_word(input logic [31:0] w);
        I_mem_ack = 1'b1; I_mem_data = w;
        tick;
        I_mem_ack = 1'b0;
    endtask

    // memory image: a fixed hash of the word address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ((a ^ 32'h5bd1_e995) * 32'h9E37_79B1) ^ (a << 7);
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] p);
        logic [31:0] w;
        w = word_at({p[31:2], 2'b00});
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] instr_at(input logic [31:0] p);
        logic [15:0] h;
        h = hw_at(p);
        return (h[1:0] != 2'b11) ? {16'h0, h} : {hw_at(p + 32'd2), h};
    endfunction

    logic        pend, redir, rdy, chk_redir;
    logic [31:0] paddr, rpc, exp_pc, e;
    int          dly, ntx;

    initial begin
        // reset values and a single 32-bit instruction
        tick; tick;
        chk("reset_valid", O_valid, 0);
        chk("reset_req", O_mem_req, 0);
        chk("reset_pc", O_pc, 32'h0);
        chk("reset_instr", O_instr, 32'h0);
        chk("reset_addr", O_mem_addr, 32'h0);
        I_reset = 1'b0;
        tick;
        chk("req_after_reset", O_mem_req, 1);
        chk("first_addr", O_mem_addr, 32'h0);
        ack_word(32'h00A0_0093);
        chk("w32_valid", O_valid, 1);
        chk("w32_instr", O_instr, 32'h00A0_0093);
        chk("w32_pc", O_pc, 32'h0);
        chk("w32_comp", O_is_compressed, 0);
        chk("w32_next_addr", O_mem_addr, 32'h4);

        // two compressed instructions in one word
        do_reset;
        tick;
        I_ready = 1'b1;
        ack_word(32'h4001_4501);
        chk("c0_instr", O_instr, 32'h0000_4501);
        chk("c0_pc", O_pc, 32'h0);
        chk("c0_comp", O_is_compressed, 1);
        tick;
        chk("c1_valid", O_valid, 1);
        chk("c1_instr", O_instr, 32'h0000_4001);
        chk("c1_pc", O_pc, 32'h2);
        chk("c1_comp", O_is_compressed, 1);

        // 32-bit instruction split across two words
        do_reset;
        tick;
        ack_word(32'h0093_4505);
        chk("s0_instr", O_instr, 32'h0000_4505);
        chk("s0_pc", O_pc, 32'h0);
        I_ready = 1'b1;
        tick;
        chk("s_gap_valid", O_valid, 0);
        chk("s_gap_req", O_mem_req, 1);
        chk("s_gap_addr", O_mem_addr, 32'h4);
        ack_word(32'h1234_0010);
        chk("s1_valid", O_valid, 1);
        chk("s1_instr", O_instr, 32'h0010_0093);
        chk("s1_pc", O_pc, 32'h2);
        chk("s1_comp", O_is_compressed, 0);

        // redirect to an odd halfword while a fetch is pending
        do_reset;
        tick;
        I_redirect = 1'b1; I_redirect_pc = 32'h103;
        tick;
        I_redirect = 1'b0;
        chk("drop_req", O_mem_req, 0);
        chk("drop_valid", O_valid, 0);
        chk("drop_pc", O_pc, 32'h102);
        ack_word(32'h1111_1111);
        chk("stale_valid", O_valid, 0);
        tick;
        chk("redir_req", O_mem_req, 1);
        chk("redir_addr", O_mem_addr, 32'h100);
        ack_word(32'hABCD_1234);
        chk("redir_valid", O_valid, 1);
        chk("redir_pc", O_pc, 32'h102);
        chk("redir_instr", O_instr, 32'h0000_ABCD);
        tick;
        chk("redir_addr2", O_mem_addr, 32'h104);

        // full buffer stalls fetching until the decoder drains it
        do_reset;
        tick;
        ack_word(32'h0093_0001);
        I_ready = 1'b1;
        tick;
        I_ready = 1'b0;
        ack_word(32'h4501_0010);
        for (int i = 0; i < 4; i++) begin
            chk("full_req", O_mem_req, 0);
            chk("full_instr", O_instr, 32'h0010_0093);
            chk("full_pc", O_pc, 32'h2);
            tick;
        end
        I_ready = 1'b1;
        tick;
        I_ready = 1'b0;
        chk("drain_instr", O_instr, 32'h0000_4501);
        chk("drain_pc", O_pc, 32'h6);
        chk("drain_req", O_mem_req, 1);
        chk("drain_addr", O_mem_addr, 32'h8);

        // asynchronous reset in the middle of a fetch
        I_reset = 1'b1;
        #1;
        chk("areset_req", O_mem_req, 0);
        chk("areset_valid", O_valid, 0);
        chk("areset_pc", O_pc, 32'h0);
        chk("areset_instr", O_instr, 32'h0);
        chk("areset_addr", O_mem_addr, 32'h0);
        tick;
        I_reset = 1'b0;
        ack_word(32'hFFFF_FFFF);
        chk("run_ack_valid", O_valid, 0);
        chk("run_ack_req", O_mem_req, 1);
        chk("run_ack_addr", O_mem_addr, 32'h0);
        ack_word(32'h00A0_0093);
        chk("post_reset_instr", O_instr, 32'h00A0_0093);
        chk("post_reset_pc", O_pc, 32'h0);

        // randomized run: responder with variable latency, random ready and redirects
        do_reset;
        pend = 1'b0; exp_pc = 32'h0; ntx = 0; chk_redir = 1'b0; dly = 0; paddr = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            redir = ($urandom % 40) == 0;
            rpc   = $urandom_range(0, 1023);
            rdy   = ($urandom % 4) != 0;
            if (chk_redir)
                chk("rand_redir_valid", O_valid, 0);
            chk_redir = redir;
            I_mem_ack = 1'b0;
            I_mem_data = $urandom;
            if (pend && O_mem_req)
                chk("rand_addr_stable", O_mem_addr, paddr);
            if (!pend && O_mem_req) begin
                pend = 1'b1; paddr = O_mem_addr; dly = $urandom_range(0, 2);
            end
            if (pend) begin
                if (dly == 0) begin
                    I_mem_ack = 1'b1; I_mem_data = word_at(paddr); pend = 1'b0;
                end else
                    dly--;
            end
            if (O_valid) begin
                e = instr_at(exp_pc);
                chk("rand_pc", O_pc, exp_pc);
                chk("rand_instr", O_instr, e);
                chk("rand_comp", O_is_compressed, e[1:0] != 2'b11);
                if (rdy && !redir) begin
                    exp_pc = exp_pc + ((e[1:0] != 2'b11) ? 32'd2 : 32'd4);
                    ntx++;
                end
            end
            if (redir)
                exp_pc = rpc & ~32'h1;
            I_redirect = redir; I_redirect_pc = rpc; I_ready = rdy;
            tick;
        end
        I_mem_ack = 1'b0; I_redirect = 1'b0;
        chk("rand_progress", ntx > 500, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
